// File: rtl/volume_pkg.sv
// Shared constants for the volume meter and the display stage that consumes its level.
package volume_pkg;

   localparam int LEVEL_MAX = 9;
   localparam int LEVEL_W   = 4;
   localparam int SAMPLE_W  = 12;

endpackage : volume_pkg

// File: rtl/level_quantizer.sv
// Maps a window peak onto a 0..LEVEL_MAX volume level with threshold compares.
// The level is the count of thresholds peak_min + k*step (k = 1..LEVEL_MAX) that
// the peak reaches, so it saturates at LEVEL_MAX and needs no divider.
module level_quantizer
   import volume_pkg::*;
(
   input  logic [SAMPLE_W-1:0] window_peak,
   input  logic [SAMPLE_W-1:0] peak_min,
   input  logic [SAMPLE_W-1:0] step,
   output logic [LEVEL_W-1:0]  level
);

   // Thresholds are built 16 bits wide so peak_min + 9*step never wraps.
   localparam int THR_W = SAMPLE_W + 4;

   logic [THR_W-1:0] thr;

   // Count every threshold the peak reaches.
   always_comb begin
      level = '0;
      thr   = '0;
      for (int k = 1; k <= LEVEL_MAX; k++) begin
         thr = {4'd0, peak_min} + THR_W'(k) * {4'd0, step};
         if ({4'd0, window_peak} >= thr) begin
            level = level + LEVEL_W'(1);
         end
      end
   end

endmodule : level_quantizer

// File: rtl/volume_level_meter.sv
// Windowed peak meter: tracks the maximum microphone sample over WINDOW_SAMPLES
// accepted samples, quantises the window peak to a 0..9 level and optionally lets
// the displayed level fall by at most one step per window.
//
// Output handshake: level_valid is a one-cycle pulse with no back-pressure; it is
// high exactly on the cycle after volume_level has been loaded with a new value,
// and volume_level holds that value until the next pulse.
module volume_level_meter
   import volume_pkg::*;
#(
   parameter int WINDOW_SAMPLES = 4000,
   parameter int PEAK_MIN       = 2048,
   parameter int STEP           = 205,
   parameter bit DECAY_EN       = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] mic_sample,
   input  logic                sample_valid,
   output logic [LEVEL_W-1:0]  volume_level,
   output logic                level_valid
);

   localparam int CNT_W = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_SAMPLES - 1);

   logic [CNT_W-1:0]    win_cnt;
   logic [SAMPLE_W-1:0] peak;
   logic [SAMPLE_W-1:0] window_peak;
   logic                eval;
   logic [SAMPLE_W-1:0] peak_with_sample;
   logic                last_sample;
   logic [LEVEL_W-1:0]  quant_level;
   logic [LEVEL_W-1:0]  next_level;

   assign peak_with_sample = (mic_sample > peak) ? mic_sample : peak;
   assign last_sample      = sample_valid && (win_cnt == CNT_LAST);

   level_quantizer u_quant (
      .window_peak (window_peak),
      .peak_min    (SAMPLE_W'(PEAK_MIN)),
      .step        (SAMPLE_W'(STEP)),
      .level       (quant_level)
   );

   // Window accumulation: count accepted samples, track the running peak and hand
   // the finished peak to the eval stage without ever stalling new samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt     <= '0;
         peak        <= '0;
         window_peak <= '0;
         eval        <= 1'b0;
      end else begin
         eval <= last_sample;
         if (sample_valid) begin
            if (last_sample) begin
               win_cnt     <= '0;
               peak        <= '0;
               window_peak <= peak_with_sample;
            end else begin
               win_cnt <= win_cnt + CNT_W'(1);
               peak    <= peak_with_sample;
            end
         end
      end
   end

   // Decay rule: rising levels jump straight up, falling levels step down by one.
   always_comb begin
      next_level = quant_level;
      if (DECAY_EN && (quant_level < volume_level)) begin
         next_level = volume_level - LEVEL_W'(1);
      end
   end

   // Output register: load the new level and pulse level_valid one cycle after eval.
   always_ff @(posedge clk) begin
      if (reset) begin
         volume_level <= '0;
         level_valid  <= 1'b0;
      end else begin
         level_valid <= eval;
         if (eval) begin
            volume_level <= next_level;
         end
      end
   end

endmodule : volume_level_meter

// File: tb/tb_volume_level_meter.sv
// Bench for volume_level_meter: one instance without decay, one with decay, both
// fed the same sample stream. Each finished window pushes the hand-computed level
// and the cycle its pulse is due into a per-instance queue; a monitor pops and
// compares whenever an instance raises level_valid.
module tb_volume_level_meter;

   localparam int NWIN = 18;

   logic        clk;
   logic        reset;
   logic [11:0] mic_sample;
   logic        sample_valid;
   logic [3:0]  level0, level1;
   logic        valid0, valid1;

   int cyc;
   int n_checks;
   int n_pass;

   // {due cycle[15:0], level[3:0]}
   logic [19:0] exp_q0[$];
   logic [19:0] exp_q1[$];

   // Window samples and expected levels (no decay / decay), computed by hand
   // with PEAK_MIN=2048, STEP=205: thresholds 2253, 2458, ..., 3893.
   logic [11:0] win_s [NWIN][4] = '{
      '{12'd100,  12'd2252, 12'd2000, 12'd50  },  // 0  peak 2252 -> 0
      '{12'd2253, 12'd0,    12'd0,    12'd0   },  // 1  peak 2253 -> 1
      '{12'd3892, 12'd10,   12'd3000, 12'd20  },  // 2  peak 3892 -> 8
      '{12'd0,    12'd0,    12'd0,    12'd3893},  // 3  peak 3893 -> 9
      '{12'd4095, 12'd4095, 12'd0,    12'd1   },  // 4  peak 4095 -> 9
      '{12'd2000, 12'd1500, 12'd2000, 12'd0   },  // 5  peak 2000 -> 0
      '{12'd2000, 12'd2000, 12'd2000, 12'd2000},  // 6
      '{12'd0,    12'd2000, 12'd5,    12'd2000},  // 7
      '{12'd3300, 12'd100,  12'd200,  12'd300 },  // 8  peak 3300 -> 6
      '{12'd2663, 12'd2662, 12'd0,    12'd2663},  // 9  peak 2663 -> 3
      '{12'd1,    12'd4095, 12'd2,    12'd3   },  // 10 peak 4095 -> 9
      '{12'd1000, 12'd500,  12'd1000, 12'd0   },  // 11 b2b peak 1000 -> 0
      '{12'd3073, 12'd3072, 12'd0,    12'd100 },  // 12 b2b peak 3073 -> 5
      '{12'd2048, 12'd2048, 12'd0,    12'd2048},  // 13 b2b peak 2048 -> 0
      '{12'd2048, 12'd2048, 12'd2048, 12'd2048},  // 14 after mid-window reset
      '{12'd1000, 12'd500,  12'd1000, 12'd0   },  // 15 gapped
      '{12'd3073, 12'd3072, 12'd0,    12'd100 },  // 16 gapped
      '{12'd2048, 12'd2048, 12'd0,    12'd2048}   // 17 gapped
   };
   logic [3:0] exp0 [NWIN] = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0, 4'd6,
                               4'd3, 4'd9, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0};
   logic [3:0] exp1 [NWIN] = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd9, 4'd8, 4'd7, 4'd6, 4'd6,
                               4'd5, 4'd9, 4'd8, 4'd7, 4'd6, 4'd0, 4'd0, 4'd5, 4'd4};

   volume_level_meter #(
      .WINDOW_SAMPLES (4),
      .PEAK_MIN       (2048),
      .STEP           (205),
      .DECAY_EN       (1'b0)
   ) u_dut0 (
      .clk          (clk),
      .reset        (reset),
      .mic_sample   (mic_sample),
      .sample_valid (sample_valid),
      .volume_level (level0),
      .level_valid  (valid0)
   );

   volume_level_meter #(
      .WINDOW_SAMPLES (4),
      .PEAK_MIN       (2048),
      .STEP           (205),
      .DECAY_EN       (1'b1)
   ) u_dut1 (
      .clk          (clk),
      .reset        (reset),
      .mic_sample   (mic_sample),
      .sample_valid (sample_valid),
      .volume_level (level1),
      .level_valid  (valid1)
   );

   // Clock and cycle counter
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Driver tasks: inputs change on the falling edge, the DUT samples on the rising one.
   task automatic drive(input logic [11:0] val);
      @(negedge clk);
      sample_valid = 1'b1;
      mic_sample   = val;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         sample_valid = 1'b0;
         mic_sample   = 12'($urandom_range(4095, 3900));
      end
   endtask

   task automatic send_window(input int w, input int max_gap);
      for (int i = 0; i < 4; i++) begin
         drive(win_s[w][i]);
         if (i == 3) begin
            exp_q0.push_back({16'(cyc + 2), exp0[w]});
            exp_q1.push_back({16'(cyc + 2), exp1[w]});
         end
         if (max_gap > 0) idle($urandom_range(max_gap, 0));
      end
   endtask

   // Scoreboard monitor: pop and compare whenever an instance pulses level_valid.
   always @(negedge clk) begin
      logic [19:0] e;
      if (!reset && valid0) begin
         if (exp_q0.size() == 0) begin
            check("dut0_unexpected_pulse", 1, 0);
         end else begin
            e = exp_q0.pop_front();
            check("dut0_level", int'(level0), int'(e[3:0]));
            check("dut0_pulse_cycle", cyc & 16'hffff, int'(e[19:4]));
         end
      end
      if (!reset && valid1) begin
         if (exp_q1.size() == 0) begin
            check("dut1_unexpected_pulse", 1, 0);
         end else begin
            e = exp_q1.pop_front();
            check("dut1_level", int'(level1), int'(e[3:0]));
            check("dut1_pulse_cycle", cyc & 16'hffff, int'(e[19:4]));
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   // Stimulus sequence
   initial begin
      int wait_cycles;
      n_checks     = 0;
      n_pass       = 0;
      cyc          = 0;
      reset        = 1'b1;
      sample_valid = 1'b0;
      mic_sample   = '0;
      repeat (3) @(negedge clk);
      check("reset_level0", int'(level0), 0);
      check("reset_level1", int'(level1), 0);
      check("reset_valid0", int'(valid0), 0);
      check("reset_valid1", int'(valid1), 0);
      reset = 1'b0;

      // Threshold, decay and rise windows with small gaps
      for (int w = 0; w <= 10; w++) send_window(w, 2);
      idle(3);

      // Back-to-back: sample_valid high for 12 consecutive cycles
      for (int w = 11; w <= 13; w++) send_window(w, 0);
      idle(3);

      // Reset mid-window, with a valid sample on the reset edge
      drive(12'd4095);
      drive(12'd4095);
      @(negedge clk);
      reset        = 1'b1;
      sample_valid = 1'b1;
      mic_sample   = 12'd4095;
      @(negedge clk);
      reset        = 1'b0;
      sample_valid = 1'b0;
      check("midreset_level1", int'(level1), 0);
      check("midreset_valid1", int'(valid1), 0);
      send_window(14, 0);
      idle(3);

      // Gapped strobes with high garbage on mic_sample while idle
      for (int w = 15; w <= 17; w++) send_window(w, 7);
      idle(3);

      // Drain: every expected pulse must have arrived
      wait_cycles = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && wait_cycles < 20) begin
         @(negedge clk);
         wait_cycles++;
      end
      check("dut0_missing_pulses", exp_q0.size(), 0);
      check("dut1_missing_pulses", exp_q1.size(), 0);
      check("final_level0", int'(level0), 0);
      check("final_level1", int'(level1), 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_volume_level_meter
